// File: rtl/bus_uart_master_pkg.sv
// Shared constants and state encodings for the UART-to-bus bridge.
package bus_uart_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StIssue,
    StWaitAck,
    StReply
  } state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/bus_uart_master_phy.sv
// 8N1 UART byte transceiver with fixed bit period.
module uart_byte_phy
  import bus_uart_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q;

  logic [9:0]  tx_shift_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_idx_q;
  logic        tx_busy_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver: half-bit start re-check, centre sampling, framing check on stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (rx_st_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_q  <= RxStart;
            rx_cnt_q <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            // Line back high at mid-start means it was only a glitch.
            rx_st_q  <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_st_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_st_q    <= RxIdle;
            rx_valid_q <= rx_sync_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  // Transmitter: shift out {stop, data, start} LSB-first; all-ones means idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_shift_q <= {1'b1, tx_data, 1'b0};
        tx_cnt_q   <= '0;
        tx_idx_q   <= '0;
        tx_busy_q  <= 1'b1;
      end
    end else if (tx_cnt_q == DivLast) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_idx_q   <= tx_idx_q + 4'd1;
      if (tx_idx_q == 4'd9) tx_busy_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign tx       = tx_shift_q[0];
  assign tx_busy  = tx_busy_q;
  assign rx_data  = rx_shift_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: rtl/bus_uart_master.sv
// UART command-frame to single 32-bit bus read/write bridge.
module bus_uart_master
  import bus_uart_master_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 434,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ACK_TIMEOUT   = 1024,
  parameter int unsigned FRAME_TIMEOUT = 16 * CLK_DIV * 10
) (
  input  logic                  bus_clk,
  input  logic                  bus_reset_l,
  input  logic                  ser_rx,
  output logic                  ser_tx,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wr_data,
  output logic [3:0]            bus_be,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [31:0]           bus_rd_data,
  input  logic                  bus_rd_ack,
  input  logic                  bus_wr_ack,
  output logic                  busy
);

  localparam int unsigned TmoMax   = (ACK_TIMEOUT > FRAME_TIMEOUT) ? ACK_TIMEOUT : FRAME_TIMEOUT;
  localparam int unsigned TmoWidth = $clog2(TmoMax + 1);
  localparam logic [TmoWidth-1:0] AckLast   = TmoWidth'(ACK_TIMEOUT - 1);
  localparam logic [TmoWidth-1:0] FrameLast = TmoWidth'(FRAME_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         addr_q, addr_d, data_q, data_d, reply_q, reply_d;
  logic [2:0]          reply_cnt_q, reply_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [TmoWidth-1:0] tmo_q, tmo_d;

  logic [7:0] rx_data;
  logic       rx_valid, tx_start, tx_busy;
  logic       unused_addr;

  uart_byte_phy #(
    .CLK_DIV (CLK_DIV)
  ) u_phy (
    .clk      (bus_clk),
    .rst_n    (bus_reset_l),
    .rx       (ser_rx),
    .tx       (ser_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (reply_q[31:24]),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  // FSM state and datapath registers.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      reply_q     <= '0;
      reply_cnt_q <= '0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reply_q     <= reply_d;
      reply_cnt_q <= reply_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state: frame parsing, ack/timeout resolution and reply queueing.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reply_d     = reply_q;
    reply_cnt_d = reply_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = (tmo_q == '1) ? tmo_q : tmo_q + TmoWidth'(1);
    unique case (state_q)
      StIdle: begin
        tmo_d      = '0;
        byte_cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_wr_d = (rx_data == CMD_WR);
            state_d = StGetAddr;
          end else begin
            reply_d     = {RSP_ERR, 24'h0};
            reply_cnt_d = 3'd1;
            state_d     = StReply;
          end
        end
      end
      StGetAddr: begin
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_d      = '0;
          if (byte_cnt_q == 2'd3) state_d = is_wr_q ? StGetData : StIssue;
        end else if (tmo_q == FrameLast) begin
          state_d = StIdle;
        end
      end
      StGetData: begin
        if (rx_valid) begin
          data_d     = {data_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_d      = '0;
          if (byte_cnt_q == 2'd3) state_d = StIssue;
        end else if (tmo_q == FrameLast) begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        // Acks in the strobe cycle are ignored; counting starts next cycle.
        tmo_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        // Ack is checked before expiry so a last-cycle ack still succeeds.
        if (is_wr_q && bus_wr_ack) begin
          reply_d     = {RSP_OK, 24'h0};
          reply_cnt_d = 3'd1;
          state_d     = StReply;
        end else if (!is_wr_q && bus_rd_ack) begin
          reply_d     = bus_rd_data;
          reply_cnt_d = 3'd4;
          state_d     = StReply;
        end else if (tmo_q == AckLast) begin
          reply_d     = {RSP_TMO, 24'h0};
          reply_cnt_d = 3'd1;
          state_d     = StReply;
        end
      end
      StReply: begin
        if (tx_start) begin
          reply_d     = {reply_q[23:0], 8'h00};
          reply_cnt_d = reply_cnt_q - 3'd1;
        end else if (reply_cnt_q == 3'd0 && !tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus_we      = (state_q == StIssue) && is_wr_q;
    bus_re      = (state_q == StIssue) && !is_wr_q;
    bus_be      = ((state_q == StIssue || state_q == StWaitAck) && is_wr_q) ? 4'hF : 4'h0;
    bus_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus_wr_data = data_q;
    busy        = (state_q != StIdle);
    tx_start    = (state_q == StReply) && (reply_cnt_q != 3'd0) && !tx_busy;
  end

  assign unused_addr = ^addr_q[1:0];

endmodule

// File: tb/tb_bus_uart_master.sv
// Directed bench for bus_uart_master: UART frame driver, TX decoder and bus slave model.
module tb_bus_uart_master;

  localparam int unsigned CLK_DIV       = 16;
  localparam int unsigned ACK_TIMEOUT   = 32;
  localparam int unsigned FRAME_TIMEOUT = 16 * CLK_DIV * 10;

  logic        bus_clk = 1'b0;
  logic        bus_reset_l;
  logic        ser_rx;
  logic        ser_tx;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [3:0]  bus_be;
  logic        bus_we, bus_re;
  logic [31:0] bus_rd_data;
  logic        bus_rd_ack, bus_wr_ack;
  logic        busy;

  bus_uart_master #(
    .CLK_DIV     (CLK_DIV),
    .ADDR_WIDTH  (32),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .ser_rx      (ser_rx),
    .ser_tx      (ser_tx),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_be      (bus_be),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_rd_data (bus_rd_data),
    .bus_rd_ack  (bus_rd_ack),
    .bus_wr_ack  (bus_wr_ack),
    .busy        (busy)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // ack delay in cycles after strobe, -1 = never
    logic        wrong;   // slave answers with the other ack type
    logic [31:0] rdata;
    int          nrep;
    logic [31:0] reply;   // expected reply bytes, left-aligned
    int          lat;     // strobe to first TX falling edge
  } vec_t;

  vec_t vecs[7];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          we_cnt, re_cnt, strobe_cyc, first_fall;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  rxq[$];
  int          slave_delay = -1;
  logic        slave_wrong = 1'b0;
  logic [31:0] slave_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge bus_clk);
    cyc = cyc + 1;
  end

  // Strobe monitor.
  initial forever begin
    @(posedge bus_clk);
    #1;
    if (bus_we || bus_re) begin
      if (bus_we) we_cnt++;
      if (bus_re) re_cnt++;
      st_addr    = bus_addr;
      st_wdata   = bus_wr_data;
      st_be      = bus_be;
      strobe_cyc = cyc;
      first_fall = -1;
    end
  end

  // Bus slave: one ack pulse a configured number of cycles after the strobe.
  initial begin
    logic w;
    bus_wr_ack  = 1'b0;
    bus_rd_ack  = 1'b0;
    bus_rd_data = '0;
    forever begin
      @(posedge bus_clk);
      #1;
      if ((bus_we || bus_re) && slave_delay >= 0) begin
        w = bus_we ^ slave_wrong;
        repeat (slave_delay) @(posedge bus_clk);
        #2;
        if (w) bus_wr_ack = 1'b1;
        else begin
          bus_rd_ack  = 1'b1;
          bus_rd_data = slave_rdata;
        end
        @(posedge bus_clk);
        #1;
        bus_wr_ack  = 1'b0;
        bus_rd_ack  = 1'b0;
        bus_rd_data = '0;
      end
    end
  end

  // TX decoder; bytes cut short by a reset are dropped.
  initial begin
    logic [7:0] b;
    logic       stop;
    int         ep;
    forever begin
      @(negedge ser_tx);
      ep = epoch;
      if (first_fall < 0) first_fall = cyc;
      repeat (CLK_DIV / 2) @(posedge bus_clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge bus_clk);
        b[i] = ser_tx;
      end
      repeat (CLK_DIV) @(posedge bus_clk);
      stop = ser_tx;
      if (stop === 1'b1 && ep == epoch) rxq.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge bus_clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge bus_clk);
    end
    ser_rx = stop;
    repeat (CLK_DIV) @(negedge bus_clk);
    ser_rx = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 6000) begin
      @(negedge bus_clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge bus_clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] act;
    slave_delay = v.delay;
    slave_wrong = v.wrong;
    slave_rdata = v.rdata;
    we_cnt = 0;
    re_cnt = 0;
    first_fall = -1;
    strobe_cyc = 0;
    rxq.delete();
    send_byte(v.is_wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(v.addr[8*i +: 8], 1'b1);
    if (v.is_wr) for (int i = 3; i >= 0; i--) send_byte(v.wdata[8*i +: 8], 1'b1);
    wait_idle({tag, " idle"});
    check({tag, " we_cnt"}, we_cnt, v.is_wr ? 32'd1 : 32'd0);
    check({tag, " re_cnt"}, re_cnt, v.is_wr ? 32'd0 : 32'd1);
    check({tag, " addr"}, st_addr, {v.addr[31:2], 2'b00});
    check({tag, " be"}, {28'd0, st_be}, v.is_wr ? 32'hF : 32'h0);
    if (v.is_wr) check({tag, " wdata"}, st_wdata, v.wdata);
    check({tag, " nrep"}, rxq.size(), v.nrep);
    for (int i = 0; i < v.nrep; i++) begin
      act = (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s rep%0d", tag, i), act, {24'd0, v.reply[31-8*i -: 8]});
    end
    check({tag, " latency"}, first_fall - strobe_cyc, v.lat);
    check({tag, " ser_tx idle"}, {31'd0, ser_tx}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //           wr    addr          wdata         dly  wrong rdata         n  reply         lat
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 3,  1'b0, 32'h0,        1, 32'h4B00_0000, 5};
    vecs[1] = '{1'b0, 32'h0000_1004, 32'h0,         1,  1'b0, 32'h1234_5678, 4, 32'h1234_5678, 3};
    vecs[2] = '{1'b0, 32'h0000_2000, 32'h0,         -1, 1'b0, 32'h0,        1, 32'h5400_0000, 34};
    vecs[3] = '{1'b1, 32'h0000_0100, 32'h1122_3344, 32, 1'b0, 32'h0,        1, 32'h4B00_0000, 34};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         0,  1'b0, 32'h9999_9999, 1, 32'h5400_0000, 34};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h5555_AAAA, 2,  1'b1, 32'h7777_7777, 1, 32'h5400_0000, 34};
    vecs[6] = '{1'b0, 32'h0000_3007, 32'h0,         5,  1'b0, 32'hA5A5_0F0F, 4, 32'hA5A5_0F0F, 7};

    ser_rx      = 1'b1;
    bus_reset_l = 1'b1;
    #1 bus_reset_l = 1'b0;
    epoch++;
    repeat (3) @(negedge bus_clk);
    check("rst ser_tx", {31'd0, ser_tx}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst strobes", {30'd0, bus_we, bus_re}, 32'd0);
    check("rst addr", bus_addr, 32'd0);
    check("rst wdata", bus_wr_data, 32'd0);
    check("rst be", {28'd0, bus_be}, 32'd0);
    bus_reset_l = 1'b1;
    repeat (5) @(negedge bus_clk);
    check("post-rst busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Unknown opcode
    we_cnt = 0;
    re_cnt = 0;
    rxq.delete();
    send_byte(8'h41, 1'b1);
    wait_idle("bad op idle");
    check("bad op nrep", rxq.size(), 1);
    if (rxq.size() > 0) check("bad op reply", {24'd0, rxq[0]}, 32'h3F);
    check("bad op strobes", we_cnt + re_cnt, 0);

    // Partial frame then silence
    rxq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (FRAME_TIMEOUT - CLK_DIV) @(negedge bus_clk);
    check("frame tmo still busy", {31'd0, busy}, 32'd1);
    repeat (2 * CLK_DIV) @(negedge bus_clk);
    check("frame tmo dropped", {31'd0, busy}, 32'd0);
    check("frame tmo no reply", rxq.size(), 0);
    check("frame tmo no strobe", we_cnt + re_cnt, 0);
    run_vec(vecs[1], "after tmo");

    // Glitch and framing error
    ser_rx = 1'b0;
    repeat (CLK_DIV / 4) @(negedge bus_clk);
    ser_rx = 1'b1;
    repeat (4 * CLK_DIV) @(negedge bus_clk);
    check("glitch ignored", {31'd0, busy}, 32'd0);
    send_byte(8'h52, 1'b0);
    repeat (4 * CLK_DIV) @(negedge bus_clk);
    check("framing ignored", {31'd0, busy}, 32'd0);
    run_vec(vecs[0], "after glitch");

    // Reset during second reply byte
    v = vecs[1];
    v.rdata = 32'hCAFE_F00D;
    slave_delay = v.delay;
    slave_wrong = 1'b0;
    slave_rdata = v.rdata;
    rxq.delete();
    send_byte(8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(v.addr[8*i +: 8], 1'b1);
    begin
      int n = 0;
      while (rxq.size() < 1 && n < 3000) begin
        @(negedge bus_clk);
        n++;
      end
    end
    check("pre-rst first byte", rxq.size(), 1);
    repeat (3 * CLK_DIV) @(negedge bus_clk);
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    #2 bus_reset_l = 1'b0;
    epoch++;
    #1;
    check("mid rst ser_tx", {31'd0, ser_tx}, 32'd1);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst be", {28'd0, bus_be}, 32'd0);
    we_cnt = 0;
    re_cnt = 0;
    repeat (10) @(negedge bus_clk);
    check("mid rst no strobe", we_cnt + re_cnt, 0);
    bus_reset_l = 1'b1;
    repeat (3 * CLK_DIV) @(negedge bus_clk);
    run_vec(vecs[3], "after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
